// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg -- shared definitions for the seven-segment scan decoder.
//   seg_state_t  : digit-capture FSM states
//   GLYPH_0..F   : active-low 7-segment hex glyphs (bit0=a .. bit6=g)
//   GLYPH_TABLE  : the same glyphs packed for indexed lookup
//   AN_BLANK     : digit-enable value with no digit selected
//   an_is_onehot_low / an_index : helpers for active-low digit enables
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } seg_state_t;

  localparam logic [7:0] AN_BLANK = 8'hFF;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Entry n holds the glyph for hex digit n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  function automatic logic an_is_onehot_low(input logic [7:0] an);
    return $onehot(~an);
  endfunction

  // Position of the low bit; only meaningful when exactly one bit is low.
  function automatic logic [2:0] an_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// ---------------------------------------------------------------------------
// seg7_to_hex -- combinational lookup of an active-low 7-segment pattern.
//   pat    in  7  segment pattern, bit0=a .. bit6=g, active-low
//   nibble out 4  matching hex digit, 0 when no glyph matches
//   hit    out 1  pattern is one of the 16 hex glyphs
// ---------------------------------------------------------------------------
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = '0;
    hit    = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pat == GLYPH_TABLE[4'(i)]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder -- recovers the displayed value from a multiplexed
// 8-digit seven-segment display by watching its segment and anode lines.
//   clk         in   1  clock, rising edge
//   RST         in   1  asynchronous reset, active-low
//   SEG         in   8  segment lines, active-low, bit7 = dp
//   AN          in   8  digit enables, active-low, digit 0 least significant
//   value       out 32  last complete frame, digit i in value[4i+3:4i]
//   dp          out  8  last complete frame decimal points, 1 = lit
//   frame_valid out  1  single-cycle pulse when value/dp update
//   pat_err     out  1  sticky: a captured digit had a non-hex pattern
//   an_err      out  1  sticky: several digits enabled while stable
//   stale       out  1  no frame completed within TIMEOUT_CYC cycles
// ---------------------------------------------------------------------------
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [7:0]  SEG,
  input  logic [7:0]  AN,
  output logic [31:0] value,
  output logic [7:0]  dp,
  output logic        frame_valid,
  output logic        pat_err,
  output logic        an_err,
  output logic        stale
);

  localparam int unsigned SW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int unsigned TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LIM = SW'(SETTLE_CYC);
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYC);

  // Two-stage input synchroniser plus the previous synchronised sample.
  logic [7:0] seg_s1, seg_s2, seg_prev;
  logic [7:0] an_s1, an_s2, an_prev;

  seg_state_t    state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_cnt_nxt;
  logic          settled;
  logic          same;
  logic          onehot;
  logic          capture;
  logic          multi_sel;
  logic [2:0]    dig_idx;
  logic [3:0]    dec_nibble;
  logic          dec_hit;

  logic [31:0]   shadow_val;
  logic [7:0]    shadow_dp;
  logic [7:0]    mask;
  logic          frame_done;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
      an_s1    <= AN_BLANK;
      an_s2    <= AN_BLANK;
      an_prev  <= AN_BLANK;
    end else begin
      seg_s1   <= SEG;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      an_s1    <= AN;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
    end
  end

  assign same    = (seg_s2 == seg_prev) && (an_s2 == an_prev);
  assign onehot  = an_is_onehot_low(an_s2);
  assign dig_idx = an_index(an_s2);

  seg7_to_hex u_dec (
    .pat    (seg_s2[6:0]),
    .nibble (dec_nibble),
    .hit    (dec_hit)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  // Any non-blank AN starts a dwell; whether it was a single digit is only
  // judged once the dwell has been stable for SETTLE_CYC samples.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    settled        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (an_s2 != AN_BLANK) begin
          settle_cnt_nxt = SW'(1);
          if (SETTLE_CYC <= 1) begin
            settled   = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (same) begin
          settle_cnt_nxt = settle_cnt + SW'(1);
          if (settle_cnt + SW'(1) == SETTLE_LIM) begin
            settled   = 1'b1;
            state_nxt = ST_HOLD;
          end
        end else begin
          settle_cnt_nxt = '0;
          state_nxt      = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!same) begin
          settle_cnt_nxt = '0;
          state_nxt      = ST_IDLE;
        end
      end
      default: begin
        settle_cnt_nxt = '0;
        state_nxt      = ST_IDLE;
      end
    endcase
  end

  assign capture    = settled && onehot;
  assign multi_sel  = settled && !onehot;
  assign frame_done = (mask == 8'hFF);

  // Publishing clears the mask, but a digit captured in that same cycle
  // must still count towards the next frame.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      shadow_val  <= '0;
      shadow_dp   <= '0;
      mask        <= '0;
      value       <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      if (capture) begin
        shadow_val[{dig_idx, 2'b00} +: 4] <= dec_nibble;
        shadow_dp[dig_idx]                <= ~seg_s2[7];
      end
      mask <= (frame_done ? 8'h00 : mask) | (capture ? ~an_s2 : 8'h00);
      frame_valid <= frame_done;
      if (frame_done) begin
        value <= shadow_val;
        dp    <= shadow_dp;
      end
      if (capture && !dec_hit) pat_err <= 1'b1;
      if (multi_sel) an_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      to_cnt <= '0;
    end else if (frame_valid) begin
      to_cnt <= '0;
    end else if (to_cnt != TIMEOUT_LIM) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign stale = (to_cnt == TIMEOUT_LIM);

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYC, default 4: consecutive identical SEG/AN samples required before a digit is captured.
REQ-002 Parameter TIMEOUT_CYC, default 200000: cycles without a completed frame before stale asserts.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 SEG  input  8  segment lines, active-low; bit0=a … bit6=g, bit7=dp.
REQ-006 AN  input  8  digit enables, active-low; AN[i]=0 selects digit i; digit 0 is least significant.
REQ-007 value  output  32  last complete frame; digit i in value[4i+3:4i].
REQ-008 dp  output  8  last complete frame decimal points; dp[i]=1 means dp lit.
REQ-009 frame_valid  output  1  one-cycle pulse when value/dp are updated.
REQ-010 pat_err  output  1  sticky; a captured digit had a non-hex segment pattern.
REQ-011 an_err  output  1  sticky; AN had more than one bit low while stable.
REQ-012 stale  output  1  high while no frame has completed within TIMEOUT_CYC cycles.

Function
REQ-013 SEG and AN shall be registered through two flip-flop stages before any use; all latencies below count from the first register.
REQ-014 The FSM shall have states IDLE, SETTLE, HOLD.
REQ-015 IDLE: AN all-ones (blank) -> stay; AN one-hot low -> SETTLE, load settle counter to 1.
REQ-016 SETTLE: sample equal to previous sample -> increment counter; on reaching SETTLE_CYC capture the digit and go to HOLD; sample changes -> back to IDLE (re-evaluated next cycle), counter cleared.
REQ-017 HOLD: stays until the sampled SEG or AN changes, then IDLE; a digit is captured at most once per dwell.
REQ-018 Capture decodes SEG[6:0] via a 16-entry table of standard hex glyphs (0=7'h40, 1=7'h79, …, F=7'h0E, active-low), stores the nibble and ~SEG[7] into slot i of a shadow buffer, and sets mask bit i.
REQ-019 An unmatched pattern shall set pat_err, store nibble 0, and still set the mask bit.
REQ-020 AN with two or more bits low for SETTLE_CYC cycles shall set an_err and capture nothing.
REQ-021 When mask reaches 8'hFF, on the next cycle value/dp shall load from the shadow buffer, frame_valid pulses for exactly one cycle, and mask clears; a capture that cycle lands in the cleared mask.
REQ-022 Recapture of an already-masked digit overwrites its shadow slot without affecting the mask.
REQ-023 Timeout counter increments each cycle, saturates at TIMEOUT_CYC, clears on frame_valid; stale = (counter == TIMEOUT_CYC).
REQ-024 pat_err and an_err clear only on reset.

Reset
REQ-025 RST low shall asynchronously force: FSM IDLE, counters 0, mask 0, shadow 0, value 0, dp 0, frame_valid 0, pat_err 0, an_err 0, stale 0.
REQ-026 Reset deassertion mid-scan shall start a fresh frame; partial pre-reset captures shall not be published.

Structure
REQ-027 Package seg_pkg shall hold the FSM state enum, the 16 glyph constants, and the blank-AN constant 8'hFF.
REQ-028 One combinational sub-module seg7_to_hex (in: 7-bit active-low pattern; out: nibble, hit flag) shall implement the glyph table.
REQ-029 Implementation target 120-400 lines of RTL total.

Verification
REQ-030 Scan digits 0..7 showing "12345678" (digit 7 = '1'), 10 cycles each -> one frame_valid, value=32'h12345678, dp=0, no errors.
REQ-031 Same scan at 3 cycles per digit with SETTLE_CYC=4 -> no capture, no frame_valid, stale rises after TIMEOUT_CYC.
REQ-032 Digit 2 driven with SEG=8'hFF (blank glyph) -> pat_err=1, frame completes with value[11:8]=0.
REQ-033 AN=8'b1111_1100 held 10 cycles -> an_err=1, mask unchanged.
REQ-034 RST pulsed low after four digits captured, then full scan of "DEADBEEF" with all dp lit (SEG[7]=0) -> single frame_valid, value=32'hDEADBEEF, dp=8'hFF.
REQ-035 Continuous repeated scans -> one frame_valid per eight captures, stale stays 0.
